// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge for single NONSEQ transfers: 1 AHB wait state minimum, 2-cycle ERROR on bad hsize or PSLVERR.
// Optional APB wait-state timeout is compiled in when APB_TIMEOUT_EN is defined.
module ahb2apb_bridge #(
  parameter int BW_HADDR    = 32,
  parameter int BW_HDATA    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ahb_hsel,
  input  logic [1:0]          ahb_htrans,
  input  logic                ahb_hwrite,
  input  logic [BW_HADDR-1:0] ahb_haddr,
  input  logic [2:0]          ahb_hsize,
  input  logic [BW_HDATA-1:0] ahb_hwdata,
  input  logic                ahb_hready,
  output logic                ahb_hreadyout,
  output logic                ahb_hresp,
  output logic [BW_HDATA-1:0] ahb_hrdata,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [BW_HADDR-1:0] apb_paddr,
  output logic [BW_HDATA-1:0] apb_pwdata,
  output logic [3:0]          apb_pstrb,
  input  logic [BW_HDATA-1:0] apb_prdata,
  input  logic                apb_pready,
  input  logic                apb_pslverr
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t                state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [BW_HADDR-1:0]   paddr_q;
  logic [BW_HDATA-1:0]   pwdata_q;
  logic [BW_HDATA-1:0]   hrdata_q;
  logic [3:0]            pstrb_q;
  logic [3:0]            strb_d;
  logic                  accept;
  logic                  xfer_ok;
  logic                  can_accept;
  logic                  unused_htrans0;

  if (BW_HDATA != 32 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("ahb2apb_bridge: BW_HDATA must be 32 and TIMEOUT_CYC in 1..255");
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
`endif

  assign unused_htrans0 = ahb_htrans[0];
  assign accept     = ahb_hsel & ahb_htrans[1] & ahb_hready;
  assign xfer_ok    = (state_q == S_ACCESS) & apb_pready & ~apb_pslverr;
  assign can_accept = (state_q == S_IDLE) | (state_q == S_ERR2) | xfer_ok;

  always_comb begin
    strb_d = 4'b0000;
    if (ahb_hwrite) begin
      case (ahb_hsize)
        3'd0:    strb_d = 4'b0001 << ahb_haddr[1:0];
        3'd1:    strb_d = ahb_haddr[1] ? 4'b1100 : 4'b0011;
        default: strb_d = 4'b1111;
      endcase
    end
  end

  // Completion in ACCESS must reach the AHB master in the same cycle as PREADY.
  assign ahb_hreadyout = (state_q == S_ACCESS) ? (apb_pready & ~apb_pslverr) : hreadyout_q;
  assign ahb_hresp     = hresp_q;
  assign ahb_hrdata    = (xfer_ok & ~pwrite_q) ? apb_prdata : hrdata_q;
  assign apb_psel      = psel_q;
  assign apb_penable   = penable_q;
  assign apb_pwrite    = pwrite_q;
  assign apb_paddr     = paddr_q;
  assign apb_pwdata    = pwdata_q;
  assign apb_pstrb     = pstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      pstrb_q     <= 4'b0000;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      if (xfer_ok & ~pwrite_q) hrdata_q <= apb_prdata;
      case (state_q)
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          if (pwrite_q) pwdata_q <= ahb_hwdata;
        end
        S_ACCESS: begin
          if (apb_pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            if (apb_pslverr) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt_q + 8'd1 == 8'(TIMEOUT_CYC)) begin
            state_q     <= S_ERR1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
      // Later assignments override the state defaults above for a new transfer.
      if (can_accept & accept) begin
        if (ahb_hsize <= 3'd2) begin
          state_q     <= S_SETUP;
          psel_q      <= 1'b1;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b0;
          pwrite_q    <= ahb_hwrite;
          paddr_q     <= ahb_haddr;
          pstrb_q     <= strb_d;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q   <= 8'd0;
`endif
        end else begin
          state_q     <= S_ERR1;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
AHB-Lite slave that converts single transfers from the core-side AHB master into APB (v2-style, with PSTRB) accesses for the peripheral bus. It sits directly downstream of the core data-port AHB master and consumes its address/data-phase signals. Only non-burst traffic is used: HTRANS is IDLE or NONSEQ, write data arrives one cycle after the address.

Parameters:
BW_HADDR, 32, AHB/APB address width
BW_HDATA, 32, AHB/APB data width (only 32 is supported)
TIMEOUT_CYC, 255, APB wait-state limit, used only with APB_TIMEOUT_EN

Ports:
clk  input  1  clock, all flops on rising edge
rst  input  1  asynchronous active-high reset
ahb_hsel  input  1  slave select
ahb_htrans  input  2  transfer type (bit1 = NONSEQ)
ahb_hwrite  input  1  1 = write
ahb_haddr  input  BW_HADDR  address
ahb_hsize  input  3  0 byte, 1 half, 2 word
ahb_hwdata  input  BW_HDATA  write data, data phase
ahb_hready  input  1  bus HREADY (address-phase qualifier)
ahb_hreadyout  output  1  slave ready
ahb_hresp  output  1  1 = ERROR
ahb_hrdata  output  BW_HDATA  read data
apb_psel  output  1  APB select
apb_penable  output  1  APB enable
apb_pwrite  output  1  APB direction
apb_paddr  output  BW_HADDR  APB address
apb_pwdata  output  BW_HDATA  APB write data
apb_pstrb  output  4  byte strobes (all 0 on reads)
apb_prdata  input  BW_HDATA  APB read data
apb_pready  input  1  APB ready
apb_pslverr  input  1  APB error

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0. Reset mid-transfer aborts the APB access immediately; no completion is signalled.
- Accept = hsel & htrans[1] & hready. On accept, register haddr, hwrite, hsize.
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0. Accept with hsize<=2 -> SETUP. Accept with hsize>2 -> ERR1, no APB access. No accept -> IDLE; IDLE/BUSY transfers get a zero-wait OKAY.
- SETUP (AHB data phase): psel=1, penable=0, hreadyout=0. Register hwdata into pwdata on writes. pstrb: word 1111; half addr[1] ? 1100 : 0011; byte 0001<<addr[1:0]; 0000 for reads. Always -> ACCESS.
- ACCESS: psel=1, penable=1; paddr, pwrite, pwdata and pstrb held stable.
  - pready=0: stay in ACCESS, hreadyout=0.
  - pready=1 & pslverr=0: hreadyout=1, hresp=0, hrdata=prdata; the read value is registered and held until the next read completes. psel and penable drop next cycle. Accept in the same cycle -> SETUP (back-to-back). Otherwise -> IDLE.
  - pready=1 & pslverr=1 -> ERR1.
- ERR1: hreadyout=0, hresp=1, psel=0. Always -> ERR2.
- ERR2: hreadyout=1, hresp=1. Accept here is honoured as in IDLE, going to SETUP or ERR1. Otherwise -> IDLE.
- Minimum latency: a zero-wait APB access completes AHB in 2 wait-free cycles after the address phase (SETUP, ACCESS); 1 AHB wait state.
- An address phase arriving while hreadyout=0 is ignored, since the bus HREADY is 0.

Optional Feature:
APB_TIMEOUT_EN: an 8-bit counter clears on SETUP entry and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYC: psel and penable deassert, the state goes to ERR1, and hrdata is unchanged. Without the macro, no counter exists and ACCESS waits indefinitely for pready.

Test Plan:
- Word write: addr 0x4000_0010, hsize 2, hwdata 0xDEADBEEF, pready=1 -> SETUP then ACCESS with paddr 0x4000_0010, pstrb 1111, pwdata 0xDEADBEEF; hreadyout low 1 cycle; hresp 0.
- Byte write to 0x...13 and half write to 0x...12 -> pstrb 1000 and 1100 respectively.
- Read with 3 pready-low cycles, prdata 0x1234_5678 -> hreadyout low 4 cycles; hrdata 0x12345678 on the completion cycle.
- pslverr=1 on completion -> hresp=1 for 2 cycles, with hreadyout 0 then 1; the next NONSEQ accepted in ERR2 starts SETUP.
- Back-to-back: a write accepted on the completion cycle of a read -> SETUP on the next cycle with no IDLE gap; hsize=3 -> 2-cycle ERROR with psel never asserted.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held 0 -> psel drops after 4 ACCESS cycles and a 2-cycle ERROR follows; assert rst mid-ACCESS -> all outputs return to their reset values immediately.
